// File: rtl/rtc_arb_pkg.sv
// Shared types and constants for the RTC APB arbiter: FSM states, RTC register map,
// latched command layout and the round-robin index helper.
package rtc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } arb_state_e;

    localparam logic [7:0] RTC_ADDR_TIME   = 8'h00;
    localparam logic [7:0] RTC_ADDR_ALARM  = 8'h04;
    localparam logic [7:0] RTC_ADDR_ADJUST = 8'h08;

    // Command fields are sized for the RTC register map; arbiter AW/DW must not exceed them.
    localparam int CMD_AW = 8;
    localparam int CMD_DW = 32;

    typedef struct packed {
        logic              write;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
    } rtc_cmd_t;

    function automatic int rr_idx(input int base, input int ofs, input int n);
        return (base + ofs) % n;
    endfunction

endpackage

// File: rtl/rtc_rr_picker.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping to 0.
module rtc_rr_picker
    import rtc_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_win,
    output logic            o_any
);

    logic [IW-1:0] w_idx;

    // Scan farthest-first so the candidate closest to i_ptr overwrites the others.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IW'(rr_idx(int'(i_ptr), k, NREQ));
            if (i_req[w_idx]) begin
                o_any = 1'b1;
                o_win = w_idx;
            end
        end
    end

endmodule

// File: rtl/rtc_apb_arbiter.sv
// Round-robin arbiter and sole APB master for the RTC completer.
// Optional ACCESS timeout with error response: define RTC_ARB_TIMEOUT_EN.
module rtc_apb_arbiter
    import rtc_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic               pready,
    input  logic [DW-1:0]      prdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e     r_state;
    logic [IW-1:0]  r_win;
    logic [IW-1:0]  r_rr_ptr;
    rtc_cmd_t       r_cmd;
    logic           r_psel;
    logic           r_pen;
    logic [NREQ-1:0] r_done;
    logic [DW-1:0]  r_rdata;

    logic [IW-1:0]  w_win;
    logic           w_any;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_wdata;

    rtc_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    assign w_addr  = req_addr[w_win*AW +: AW];
    assign w_wdata = req_wdata[w_win*DW +: DW];

`ifdef RTC_ARB_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic           r_err;
    logic [TCW-1:0] r_tcnt;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // The latched command doubles as the APB address/data/direction registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state  <= ST_IDLE;
            r_win    <= '0;
            r_rr_ptr <= '0;
            r_cmd    <= '0;
            r_psel   <= 1'b0;
            r_pen    <= 1'b0;
            r_done   <= '0;
            r_rdata  <= '0;
`ifdef RTC_ARB_TIMEOUT_EN
            r_err    <= 1'b0;
            r_tcnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_cmd   <= '{write: req_write[w_win],
                                     addr:  CMD_AW'(w_addr),
                                     wdata: CMD_DW'(w_wdata)};
                        r_psel  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_pen   <= 1'b1;
`ifdef RTC_ARB_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_psel  <= 1'b0;
                        r_pen   <= 1'b0;
                        r_done  <= NREQ'(1) << r_win;
                        r_rdata <= r_cmd.write ? '0 : prdata;
`ifdef RTC_ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= ST_RESP;
                    end
`ifdef RTC_ARB_TIMEOUT_EN
                    else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
                        r_psel  <= 1'b0;
                        r_pen   <= 1'b0;
                        r_done  <= NREQ'(1) << r_win;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_done   <= '0;
                    r_rr_ptr <= IW'(rr_idx(int'(r_win), 1, NREQ));
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign psel      = r_psel;
    assign penable   = r_pen;
    assign pwrite    = r_cmd.write;
    assign paddr     = AW'(r_cmd.addr);
    assign pwdata    = DW'(r_cmd.wdata);

endmodule

// File: tb/tb_rtc_apb_arbiter.sv
// Scoreboard bench for rtc_apb_arbiter: transaction-level round-robin model plus an APB memory slave.
module tb_rtc_apb_arbiter;
    import rtc_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            preset;
    logic [N-1:0]    req, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic            rsp_err, psel, penable, pwrite, pready;
    logic [AW-1:0]   paddr;

    rtc_apb_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  slv_mem [256];
    logic [31:0]  mdl_mem [256];
    int           mdl_ptr   = 0;
    int           slv_waits = 0;
    bit           slv_rand  = 0;
    bit           slv_stall = 0;
    bit           auto_drop = 1;
    logic [N-1:0] last_done = '0;
    int           n_done    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one granted requester completes, pointer moves past it.
    function automatic void push_one(input int i, input int c);
        exp_t e;
        logic [7:0] a;
        a       = req_addr[i*AW +: AW];
        e.idx   = i;
        e.err   = 1'b0;
        e.cyc   = c;
        if (req_write[i]) begin
            e.rdata    = '0;
            mdl_mem[a] = req_wdata[i*DW +: DW];
        end else begin
            e.rdata    = mdl_mem[a];
        end
        exp_q.push_back(e);
        mdl_ptr = (i + 1) % N;
    endfunction

    // Simultaneous requests are served in cyclic order starting at the pointer.
    function automatic void push_model(input logic [N-1:0] mask, input int first_cyc);
        int start;
        int i;
        bit first;
        start = mdl_ptr;
        first = 1'b1;
        for (int k = 0; k < N; k++) begin
            i = (start + k) % N;
            if (mask[i]) begin
                push_one(i, first ? first_cyc : -1);
                first = 1'b0;
            end
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge pclk) begin
        exp_t e;
        last_done = done;
        if (done != '0) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_vec", 64'(done), 64'(4'b0001 << e.idx));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Requesters drop req the cycle after their done pulse.
    always @(posedge pclk) begin
        #1;
        if (auto_drop) req = req & ~last_done;
    end

    // APB memory slave with configurable wait states; checks outputs hold during waits.
    int         slv_w = 0;
    bit         prev_wait = 0;
    logic [42:0] prev_cmd;
    always @(posedge pclk) begin
        #1;
        if (preset) begin
            pready    = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait)
                chk("apb_stable", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(prev_cmd));
            prev_wait = 1'b0;
            if (psel && !penable) begin
                slv_w  = slv_rand ? $urandom_range(0, 3) : slv_waits;
                pready = 1'b0;
                prdata = $urandom;
            end else if (psel && penable) begin
                if (!slv_stall && slv_w == 0) begin
                    pready = 1'b1;
                    if (pwrite) slv_mem[paddr] = pwdata;
                    else        prdata = slv_mem[paddr];
                end else begin
                    pready    = 1'b0;
                    prdata    = $urandom;
                    if (slv_w > 0) slv_w--;
                    prev_wait = 1'b1;
                    prev_cmd  = {psel, penable, pwrite, paddr, pwdata};
                end
            end else begin
                pready = 1'b0;
            end
        end
    end

    task automatic set_cmd(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d);
        req_write[i]         = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic check_reset_outs();
        chk("rst_psel", 64'(psel), 0);
        chk("rst_penable", 64'(penable), 0);
        chk("rst_pwrite", 64'(pwrite), 0);
        chk("rst_paddr", 64'(paddr), 0);
        chk("rst_pwdata", 64'(pwdata), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rdata", 64'(rsp_rdata), 0);
        chk("rst_err", 64'(rsp_err), 0);
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        chk("pending_at_reset", 64'(exp_q.size()), 0);
        exp_q.delete();
        preset  = 1'b1;
        req     = '0;
        mdl_ptr = 0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req != '0 || exp_q.size() != 0) && n < budget) begin
            @(posedge pclk); #1;
            n++;
        end
        checks++;
        if (req != '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle actual pending=%0d req=%b required idle within %0d cycles",
                     exp_q.size(), req, budget);
            exp_q.delete();
            do_reset();
        end
    endtask

    task automatic launch(input logic [N-1:0] mask, input int first_ofs, input bit push, output int c0);
        @(posedge pclk); #1;
        c0  = cyc;
        req = mask;
        if (push) push_model(mask, (first_ofs < 0) ? -1 : c0 + first_ofs);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int          c0;
        int          base;
        logic [31:0] v;
        logic [N-1:0] mask;
        preset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0;
        for (int k = 0; k < 256; k++) begin
            v = $urandom;
            slv_mem[k] = v;
            mdl_mem[k] = v;
        end

        // Reset values and quiet idle
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_reset_outs();
        @(posedge pclk); #1 preset = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            chk("idle_psel", 64'(psel), 0);
        end

        // Single read, zero wait states
        slv_mem[RTC_ADDR_TIME] = 32'h0000_1234;
        mdl_mem[RTC_ADDR_TIME] = 32'h0000_1234;
        set_cmd(1, 1'b0, RTC_ADDR_TIME, $urandom);
        launch(4'b0010, 3, 1'b1, c0);
        @(negedge pclk);
        @(negedge pclk);
        chk("c1_psel_penable", 64'({psel, penable}), 64'(2'b10));
        chk("c1_paddr", 64'(paddr), 64'(RTC_ADDR_TIME));
        chk("c1_pwrite", 64'(pwrite), 0);
        @(negedge pclk);
        chk("c2_psel_penable", 64'({psel, penable}), 64'(2'b11));
        wait_idle(50);

        // Write with three wait states; command changes after grant must be ignored
        slv_waits = 3;
        set_cmd(3, 1'b1, RTC_ADDR_ALARM, 32'hA5A5_0001);
        launch(4'b1000, 6, 1'b1, c0);
        @(negedge pclk);
        @(negedge pclk);
        chk("wr_pwrite", 64'(pwrite), 1);
        chk("wr_paddr", 64'(paddr), 64'(RTC_ADDR_ALARM));
        chk("wr_pwdata", 64'(pwdata), 64'(32'hA5A5_0001));
        @(posedge pclk); #1;
        set_cmd(3, 1'b0, 8'hFF, $urandom);
        wait_idle(50);
        slv_waits = 0;
        set_cmd(0, 1'b0, RTC_ADDR_ALARM, '0);
        launch(4'b0001, 3, 1'b1, c0);
        wait_idle(50);

        // Continuous requests from all: 0,1,2,3,0 four cycles apart
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 8'(i * 4), '0);
        @(posedge pclk); #1;
        c0   = cyc;
        base = n_done;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) push_one(k % N, c0 + 3 + 4 * k);
        for (int n = 0; n < 40 && n_done < base + 5; n++) begin
            @(posedge pclk); #1;
        end
        req = '0;
        auto_drop = 1'b1;
        wait_idle(30);

        // Reset during ACCESS discards the command and returns the pointer to 0
        set_cmd(1, 1'b0, RTC_ADDR_ADJUST, '0);
        launch(4'b0010, 3, 1'b1, c0);
        wait_idle(50);
        slv_waits = 5;
        set_cmd(2, 1'b0, RTC_ADDR_ADJUST, '0);
        launch(4'b0100, 0, 1'b0, c0);
        repeat (4) @(negedge pclk);
        chk("abort_in_access", 64'(penable), 1);
        #2 preset = 1'b1;
        #1 check_reset_outs();
        mdl_ptr = 0;
        req = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        slv_waits = 0;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 8'(i * 4 + 16), '0);
        launch(4'b1011, 3, 1'b1, c0);
        wait_idle(50);

        // Random request subsets, commands and wait states
        slv_rand = 1'b1;
        repeat (40) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 4), $urandom);
            launch(mask, -1, 1'b1, c0);
            wait_idle(200);
        end
        slv_rand = 1'b0;

        // Completer that never answers
        slv_stall = 1'b1;
        set_cmd(0, 1'b0, RTC_ADDR_TIME, '0);
`ifdef RTC_ARB_TIMEOUT_EN
        launch(4'b0001, 0, 1'b0, c0);
        exp_q.push_back('{idx: mdl_ptr, rdata: 32'h0, err: 1'b1, cyc: c0 + 18});
        wait_idle(60);
        slv_stall = 1'b0;
`else
        launch(4'b0001, 0, 1'b0, c0);
        repeat (101) @(negedge pclk);
        chk("stall_c100_psel_penable", 64'({psel, penable}), 64'(2'b11));
        chk("stall_c100_cycle", 64'(cyc), 64'(c0 + 100));
        slv_stall = 1'b0;
        do_reset();
`endif
        repeat (3) @(posedge pclk);
        chk("final_psel", 64'(psel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
